axi4_gpio_bank: RTL and testbench

//  Parametrised AXI4 (full, burst-capable) GPIO slave with a native 64-bit data bus, so no width converter is needed.

---
 rtl/axi4_gpio_bank.sv | 224 ++++++++++++++++++++++
 tb/tb_axi4_gpio_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_gpio_bank.sv
// axi4_gpio_bank: AXI4 burst-capable GPIO slave on a native 64-bit data bus.
// Per-pin direction, atomic SET/CLR, synchronised inputs, rising-edge interrupt.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | accepting write beats, one per cycle
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, presenting the current beat until rready
module axi4_gpio_bank #(
    parameter int ID_W        = 4,
    parameter int ADDR_W      = 12,
    parameter int GPIO_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              RSTn,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [63:0]       s_axi_wdata,
    input  logic [7:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [63:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_t,
    output logic              irq
);

    localparam logic [63:0] PIN_MASK = {64{1'b1}} >> (64 - GPIO_W);
    localparam logic [2:0]  A_DOUT = 3'd0, A_DIR = 3'd1, A_DIN = 3'd2, A_IEN = 3'd3,
                            A_ISTAT = 3'd4, A_SET = 3'd5, A_CLR = 3'd6, A_BAD = 3'd7;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t            r_wstate;
    r_state_t            r_rstate;
    logic                r_awready, r_wready, r_bvalid, r_werr;
    logic [1:0]          r_bresp;
    logic [ID_W-1:0]     r_bid, r_rid;
    logic [ADDR_W-1:0]   r_waddr, r_raddr;
    logic [7:0]          r_wlen, r_wcnt, r_rlen, r_rcnt;
    logic [2:0]          r_wsize, r_rsize;
    logic [1:0]          r_wburst, r_rburst, r_rresp;
    logic                r_arready, r_rvalid, r_rlast, r_irq;
    logic [63:0]         r_rdata;
    logic [63:0]         r_dout, r_dir, r_ien, r_istat;
    logic [GPIO_W-1:0]   r_sync [SYNC_STAGES];
    logic [GPIO_W-1:0]   r_din_prev;

    logic                w_wbeat;
    logic [63:0]         w_wmask, w_wbits, w_w1c, w_rd_data;
    logic [2:0]          w_rsel;
    logic [GPIO_W-1:0]   w_din, w_edge;

    // FIXED holds the address; INCR and WRAP both step by the beat size.
    function automatic logic [ADDR_W-1:0] f_step(input logic [ADDR_W-1:0] a,
                                                 input logic [2:0] sz, input logic [1:0] bt);
        if (bt == 2'b00) return a;
        return a + (ADDR_W'(1) << sz);
    endfunction

    assign w_wbeat = (r_wstate == W_DATA) && r_wready && s_axi_wvalid;
    assign w_wbits = s_axi_wdata & w_wmask & PIN_MASK;
    assign w_w1c   = (w_wbeat && r_waddr[5:3] == A_ISTAT) ? w_wbits : 64'd0;
    assign w_din   = r_sync[SYNC_STAGES-1];
    assign w_edge  = w_din & ~r_din_prev;
    // During R_IDLE the read mux looks at the incoming AR address so beat 0 is ready next cycle.
    assign w_rsel  = (r_rstate == R_IDLE) ? s_axi_araddr[5:3] : r_raddr[5:3];

    // Expand byte strobes into a bit mask.
    always_comb begin
        w_wmask = 64'd0;
        for (int b = 0; b < 8; b++) w_wmask[8*b +: 8] = {8{s_axi_wstrb[b]}};
    end

    // Read mux over the register map; write-only and unmapped offsets read 0.
    always_comb begin
        w_rd_data = 64'd0;
        case (w_rsel)
            A_DOUT:  w_rd_data = r_dout;
            A_DIR:   w_rd_data = r_dir;
            A_DIN:   w_rd_data = 64'(w_din);
            A_IEN:   w_rd_data = r_ien;
            A_ISTAT: w_rd_data = r_istat;
            default: w_rd_data = 64'd0;
        endcase
    end

    // Write channel FSM: address capture, beat counting, error accumulation, response.
    always_ff @(posedge sys_clk) begin
        if (!RSTn) begin
            r_wstate <= W_IDLE; r_awready <= 1'b1; r_wready <= 1'b0; r_bvalid <= 1'b0;
            r_bresp <= OKAY; r_bid <= '0; r_waddr <= '0; r_wlen <= '0; r_wsize <= '0;
            r_wburst <= '0; r_wcnt <= '0; r_werr <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (s_axi_awvalid) begin
                    r_bid <= s_axi_awid; r_waddr <= s_axi_awaddr; r_wlen <= s_axi_awlen;
                    r_wsize <= s_axi_awsize; r_wburst <= s_axi_awburst;
                    r_wcnt <= '0; r_werr <= 1'b0;
                    r_awready <= 1'b0; r_wready <= 1'b1; r_wstate <= W_DATA;
                end
                W_DATA: if (s_axi_wvalid) begin
                    r_waddr <= f_step(r_waddr, r_wsize, r_wburst);
                    r_wcnt  <= r_wcnt + 8'd1;
                    r_werr  <= r_werr | (r_waddr[5:3] == A_BAD);
                    if (s_axi_wlast || r_wcnt == r_wlen) begin
                        r_wready <= 1'b0; r_bvalid <= 1'b1; r_wstate <= W_RESP;
                        r_bresp  <= (r_werr || r_waddr[5:3] == A_BAD) ? SLVERR : OKAY;
                    end
                end
                W_RESP: if (s_axi_bready) begin
                    r_bvalid <= 1'b0; r_awready <= 1'b1; r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: registered beat data, held stable until the handshake.
    always_ff @(posedge sys_clk) begin
        if (!RSTn) begin
            r_rstate <= R_IDLE; r_arready <= 1'b1; r_rvalid <= 1'b0; r_rlast <= 1'b0;
            r_rdata <= '0; r_rresp <= OKAY; r_rid <= '0; r_raddr <= '0; r_rlen <= '0;
            r_rsize <= '0; r_rburst <= '0; r_rcnt <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (s_axi_arvalid) begin
                    r_rid <= s_axi_arid; r_rlen <= s_axi_arlen; r_rsize <= s_axi_arsize;
                    r_rburst <= s_axi_arburst;
                    r_raddr <= f_step(s_axi_araddr, s_axi_arsize, s_axi_arburst);
                    r_rcnt <= '0; r_arready <= 1'b0; r_rvalid <= 1'b1;
                    r_rdata <= w_rd_data; r_rresp <= (w_rsel == A_BAD) ? SLVERR : OKAY;
                    r_rlast <= (s_axi_arlen == 8'd0); r_rstate <= R_DATA;
                end
                R_DATA: if (s_axi_rready) begin
                    if (r_rlast) begin
                        r_rvalid <= 1'b0; r_rlast <= 1'b0; r_arready <= 1'b1; r_rstate <= R_IDLE;
                    end else begin
                        r_rdata <= w_rd_data; r_rresp <= (w_rsel == A_BAD) ? SLVERR : OKAY;
                        r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        r_rcnt  <= r_rcnt + 8'd1;
                        r_raddr <= f_step(r_raddr, r_rsize, r_rburst);
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Register file; a new edge overrides a simultaneous W1C on the same bit.
    always_ff @(posedge sys_clk) begin
        if (!RSTn) begin
            r_dout <= '0; r_dir <= '0; r_ien <= '0; r_istat <= '0; r_irq <= 1'b0;
        end else begin
            r_istat <= (r_istat & ~w_w1c) | 64'(w_edge);
            r_irq   <= |(r_istat & r_ien);
            if (w_wbeat) begin
                case (r_waddr[5:3])
                    A_DOUT:  r_dout <= (r_dout & ~w_wmask) | w_wbits;
                    A_DIR:   r_dir  <= (r_dir  & ~w_wmask) | w_wbits;
                    A_IEN:   r_ien  <= (r_ien  & ~w_wmask) | w_wbits;
                    A_SET:   r_dout <= r_dout | w_wbits;
                    A_CLR:   r_dout <= r_dout & ~w_wbits;
                    default: ;
                endcase
            end
        end
    end

    // Input synchroniser plus the previous-cycle copy used for edge detection.
    always_ff @(posedge sys_clk) begin
        if (!RSTn) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_din_prev <= '0;
        end else begin
            r_sync[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_din_prev <= w_din;
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_arready = r_arready;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rvalid  = r_rvalid;
    assign gpio_o        = r_dout[GPIO_W-1:0];
    assign gpio_t        = ~r_dir[GPIO_W-1:0];
    assign irq           = r_irq;

endmodule

// File: tb/tb_axi4_gpio_bank.sv
// Scoreboard bench for axi4_gpio_bank: expected B/R results are queued as each
// transaction is issued and popped as the DUT responds.
module tb_axi4_gpio_bank;

    localparam int ID_W = 4, ADDR_W = 12, GPIO_W = 8, SYNC_STAGES = 2;

    logic              sys_clk = 1'b0;
    logic              RSTn = 1'b0;
    logic [ID_W-1:0]   s_axi_awid = '0, s_axi_arid = '0;
    logic [ADDR_W-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]        s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0]        s_axi_awsize = 3'd3, s_axi_arsize = 3'd3;
    logic [1:0]        s_axi_awburst = 2'b01, s_axi_arburst = 2'b01;
    logic              s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic              s_axi_awready, s_axi_arready;
    logic [63:0]       s_axi_wdata = '0;
    logic [7:0]        s_axi_wstrb = '0;
    logic              s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
    logic [ID_W-1:0]   s_axi_bid, s_axi_rid;
    logic [1:0]        s_axi_bresp, s_axi_rresp;
    logic              s_axi_bvalid, s_axi_bready = 1'b0;
    logic [63:0]       s_axi_rdata;
    logic              s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;
    logic [GPIO_W-1:0] gpio_i = '0, gpio_o, gpio_t;
    logic              irq;

    axi4_gpio_bank #(.ID_W(ID_W), .ADDR_W(ADDR_W), .GPIO_W(GPIO_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .sys_clk(sys_clk), .RSTn(RSTn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .irq(irq)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t     sb_r[$];
    logic [1:0] sb_b[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [63:0] wd[8];
    logic [7:0]  ws[8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push_r(input logic [63:0] d, input logic [1:0] r, input logic l);
        rbeat_t e;
        e.data = d; e.resp = r; e.last = l;
        sb_r.push_back(e);
    endtask

    // INCR write burst from wd/ws; called and returns on a negedge.
    task automatic axi_wr(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input logic [1:0] exp_resp);
        int t;
        logic [1:0] e;
        sb_b.push_back(exp_resp);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = 3'd3; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < 50) begin @(negedge sys_clk); t++; end
        chk("awready", s_axi_awready, 1);
        @(negedge sys_clk);
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wdata = wd[b]; s_axi_wstrb = ws[b];
            s_axi_wlast = (b == int'(len)); s_axi_wvalid = 1'b1;
            t = 0;
            while (!s_axi_wready && t < 50) begin @(negedge sys_clk); t++; end
            chk("wready", s_axi_wready, 1);
            @(negedge sys_clk);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        t = 0;
        while (!s_axi_bvalid && t < 50) begin @(negedge sys_clk); t++; end
        chk("bvalid", s_axi_bvalid, 1);
        e = (sb_b.size() > 0) ? sb_b.pop_front() : 2'bxx;
        chk("bresp", s_axi_bresp, e);
        chk("bid", s_axi_bid, id);
        s_axi_bready = 1'b1;
        @(negedge sys_clk);
        s_axi_bready = 1'b0;
        chk("bvalid_drop", s_axi_bvalid, 0);
        chk("awready_back", s_axi_awready, 1);
    endtask

    // INCR read burst; with stall, each beat is held one extra cycle before rready.
    task automatic axi_rd(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input bit stall);
        int t;
        rbeat_t e;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = 3'd3; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 50) begin @(negedge sys_clk); t++; end
        chk("arready", s_axi_arready, 1);
        @(negedge sys_clk);
        s_axi_arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!s_axi_rvalid && t < 50) begin @(negedge sys_clk); t++; end
            chk("rvalid", s_axi_rvalid, 1);
            e = (sb_r.size() > 0) ? sb_r.pop_front() : 'x;
            if (stall) begin
                chk("rdata_stall", s_axi_rdata, e.data);
                chk("rresp_stall", s_axi_rresp, e.resp);
                @(negedge sys_clk);
                chk("rvalid_stall", s_axi_rvalid, 1);
            end
            chk("rdata", s_axi_rdata, e.data);
            chk("rresp", s_axi_rresp, e.resp);
            chk("rlast", s_axi_rlast, e.last);
            chk("rid", s_axi_rid, id);
            s_axi_rready = 1'b1;
            @(negedge sys_clk);
            s_axi_rready = 1'b0;
        end
        chk("r_done", s_axi_rvalid, 0);
        chk("arready_back", s_axi_arready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_awready", s_axi_awready, 1);
        chk("rst_arready", s_axi_arready, 1);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_rlast", s_axi_rlast, 0);
        chk("rst_gpio_o", gpio_o, 8'h00);
        chk("rst_gpio_t", gpio_t, 8'hFF);
        chk("rst_irq", irq, 0);
        RSTn = 1'b1;
        @(negedge sys_clk);

        // 1: single write, then read back
        wd[0] = 64'hA5; ws[0] = 8'h01;
        axi_wr(4'h3, 12'h000, 8'd0, 2'b00);
        chk("t1_gpio_o", gpio_o, 8'hA5);
        push_r(64'hA5, 2'b00, 1'b1);
        axi_rd(4'h6, 12'h000, 8'd0, 1'b0);

        // 2: 3-beat burst across DATA_OUT, DIR and the read-only DATA_IN
        wd[0] = 64'hFF; ws[0] = 8'h01;
        wd[1] = 64'h0F; ws[1] = 8'hFF;
        wd[2] = 64'h03; ws[2] = 8'hFF;
        axi_wr(4'h1, 12'h000, 8'd2, 2'b00);
        chk("t2_gpio_t", gpio_t, 8'hF0);
        chk("t2_gpio_o", gpio_o, 8'hFF);
        push_r(64'h0F, 2'b00, 1'b0);
        push_r(64'h00, 2'b00, 1'b1);
        axi_rd(4'h2, 12'h008, 8'd1, 1'b0);

        // 3: SET / CLR
        wd[0] = 64'hF0; ws[0] = 8'hFF;
        axi_wr(4'h4, 12'h000, 8'd0, 2'b00);
        chk("t3_dout", gpio_o, 8'hF0);
        wd[0] = 64'h0F;
        axi_wr(4'h4, 12'h028, 8'd0, 2'b00);
        chk("t3_set", gpio_o, 8'hFF);
        wd[0] = 64'h30;
        axi_wr(4'h4, 12'h030, 8'd0, 2'b00);
        chk("t3_clr", gpio_o, 8'hCF);
        push_r(64'h0, 2'b00, 1'b0);
        push_r(64'h0, 2'b00, 1'b1);
        axi_rd(4'h5, 12'h028, 8'd1, 1'b0);

        // 4: edge interrupt and W1C
        wd[0] = 64'h01; ws[0] = 8'hFF;
        axi_wr(4'h7, 12'h018, 8'd0, 2'b00);
        chk("t4_irq_idle", irq, 0);
        gpio_i = 8'h01;
        repeat (SYNC_STAGES + 1) @(negedge sys_clk);
        chk("t4_irq_pre", irq, 0);
        @(negedge sys_clk);
        chk("t4_irq_set", irq, 1);
        push_r(64'h01, 2'b00, 1'b0);
        push_r(64'h01, 2'b00, 1'b0);
        push_r(64'h01, 2'b00, 1'b1);
        axi_rd(4'h8, 12'h010, 8'd2, 1'b0);
        wd[0] = 64'h01; ws[0] = 8'hFF;
        axi_wr(4'h9, 12'h020, 8'd0, 2'b00);
        chk("t4_irq_clr", irq, 0);
        push_r(64'h00, 2'b00, 1'b1);
        axi_rd(4'h9, 12'h020, 8'd0, 1'b0);

        // 5: stalled 4-beat read through CLR, unmapped, wrapped DATA_OUT, DIR
        push_r(64'h00, 2'b00, 1'b0);
        push_r(64'h00, 2'b10, 1'b0);
        push_r(64'hCF, 2'b00, 1'b0);
        push_r(64'h0F, 2'b00, 1'b1);
        axi_rd(4'hA, 12'h030, 8'd3, 1'b1);

        // unmapped write: SLVERR and no side effect
        wd[0] = 64'hFF; ws[0] = 8'hFF;
        axi_wr(4'hB, 12'h038, 8'd0, 2'b10);
        chk("slverr_gpio_o", gpio_o, 8'hCF);

        // 6: reset in the middle of a write burst and a read burst
        gpio_i = 8'h00;
        s_axi_awid = 4'h5; s_axi_awaddr = 12'h000; s_axi_awlen = 8'd3; s_axi_awvalid = 1'b1;
        @(negedge sys_clk);
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 64'h55; s_axi_wstrb = 8'h01; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
        @(negedge sys_clk);
        s_axi_wvalid = 1'b0;
        chk("t6_mid_gpio_o", gpio_o, 8'h55);
        s_axi_araddr = 12'h000; s_axi_arlen = 8'd3; s_axi_arvalid = 1'b1;
        @(negedge sys_clk);
        s_axi_arvalid = 1'b0;
        chk("t6_mid_rvalid", s_axi_rvalid, 1);
        RSTn = 1'b0;
        @(negedge sys_clk);
        RSTn = 1'b1;
        chk("t6_bvalid", s_axi_bvalid, 0);
        chk("t6_rvalid", s_axi_rvalid, 0);
        chk("t6_wready", s_axi_wready, 0);
        chk("t6_gpio_o", gpio_o, 8'h00);
        chk("t6_gpio_t", gpio_t, 8'hFF);
        chk("t6_awready", s_axi_awready, 1);
        chk("t6_arready", s_axi_arready, 1);
        repeat (3) @(negedge sys_clk);
        chk("t6_no_b", s_axi_bvalid, 0);
        chk("t6_no_r", s_axi_rvalid, 0);
        push_r(64'h00, 2'b00, 1'b1);
        axi_rd(4'hC, 12'h000, 8'd0, 1'b0);

        chk("sb_r_empty", 64'(sb_r.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
